lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in REQ plus WAIT before a bus error is reported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  pipeline presents a memory operation.
REQ-005 req_ready  output  1  controller accepts an operation (high only in IDLE).
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  result available; held until accepted.
REQ-011 resp_ready  input  1  pipeline accepts the result.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  2  0 = ok, 1 = misaligned/illegal funct3, 2 = bus timeout.
REQ-014 mem_req  output  1  memory request, held until mem_gnt.
REQ-015 mem_we  output  1  write enable.
REQ-016 mem_addr  output  32  word address {req_addr[31:2],2'b00}.
REQ-017 mem_wstrb  output  4  byte strobes.
REQ-018 mem_wdata  output  32  lane-aligned write data.
REQ-019 mem_gnt  input  1  memory accepted request this cycle.
REQ-020 mem_rvalid  input  1  read data valid, at least 1 cycle after mem_gnt.
REQ-021 mem_rdata  input  32  read word.

Function
REQ-022 FSM states IDLE, REQ, WAIT, RESP; exactly one active.
REQ-023 IDLE: req_ready=1; on req_valid, latch store/funct3/addr/wdata; check legality; legal -> REQ next cycle; illegal -> RESP with resp_err=1 and no memory access.
REQ-024 Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-025 REQ: mem_req=1 with stable mem_addr/mem_we/mem_wstrb/mem_wdata; on mem_gnt, store -> RESP, load -> WAIT.
REQ-026 Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; mem_wdata = wdata shifted left by 8*addr[1:0]; mem_wstrb=0 for loads.
REQ-027 WAIT: on mem_rvalid, shift mem_rdata right by 8*addr[1:0], sign/zero extend per funct3, register into resp_rdata, -> RESP.
REQ-028 Latency, zero-wait memory: store accept-to-resp_valid 2 cycles; load with rvalid one cycle after gnt, 3 cycles.
REQ-029 Timeout counter clears on leaving IDLE, counts each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> RESP with resp_err=2, mem_req dropped; a late mem_rvalid in IDLE/RESP is ignored.
REQ-030 RESP: resp_valid=1, resp_rdata/resp_err stable; on resp_ready -> IDLE; next operation accepted the following cycle (no same-cycle back-to-back).
REQ-031 mem_gnt and timeout in same cycle: gnt wins. mem_rvalid and timeout in same cycle: rvalid wins.
REQ-032 mem_gnt/mem_rvalid outside their owning state are ignored.

Reset
REQ-033 rst high at a clock edge forces IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, regardless of state.
REQ-034 Reset mid-transaction abandons it; no resp_valid is produced for it.

Structure
REQ-035 FSM state encoding, funct3 constants and resp_err codes live in shared package lsu_pkg.
REQ-036 Load extension is sub-module load_ext (funct3, aligned word in, extended word out), instantiated once after the lane shift.
REQ-037 Target 150-300 lines RTL; all outputs registered except req_ready.

Verification
REQ-038 LB addr 0x1003, mem_rdata 0x80FF_0000, gnt and rvalid 1 cycle each -> resp_rdata 0xFFFF_FF80, err 0, resp_valid 3 cycles after accept.
REQ-039 LHU addr 0x2002, mem_rdata 0xBEEF_1234 -> resp_rdata 0x0000_BEEF; LW addr 0x2001 -> err 1, mem_req never asserted.
REQ-040 SB addr 0x3002 wdata 0x0000_00AB -> mem_wstrb 4'b0100, mem_wdata 0x00AB_0000, mem_addr 0x3000; SH addr 0x3002 -> mem_wstrb 4'b1100.
REQ-041 TIMEOUT_CYCLES=8, mem_gnt held low -> resp_err 2 after 8 cycles in REQ, mem_req deasserted; later mem_rvalid ignored.
REQ-042 resp_ready held low 5 cycles -> resp_valid and resp_rdata stable throughout; req_ready 0 until cycle after handshake.
REQ-043 rst asserted in WAIT -> next cycle IDLE, all outputs 0; subsequent LW addr 0x0 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: FSM states, RISC-V
// width codes, response error codes and access legality/strobe helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Unsigned widths exist only for loads; halfwords need even, words 4-byte alignment.
  function automatic logic lsu_legal(input logic store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of a right-aligned load word according to funct3.
module load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = i_word;
    case (i_funct3)
      F3_B:    o_word = {{24{i_word[7]}}, i_word[7:0]};
      F3_H:    o_word = {{16{i_word[15]}}, i_word[15:0]};
      F3_BU:   o_word = {24'd0, i_word[7:0]};
      F3_HU:   o_word = {16'd0, i_word[15:0]};
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding memory operation, lane
// alignment, load extension and a REQ+WAIT bus timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  r_state, w_state_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [CW-1:0] r_cnt;

  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_legal;
  logic        w_timeout;
  logic [31:0] w_lane;
  logic [31:0] w_ext;
  logic [31:0] w_rdata_next;
  logic [1:0]  w_err_next;

  assign w_accept  = (r_state == ST_IDLE) & req_valid;
  assign w_legal   = lsu_legal(req_store, req_funct3, req_addr[1:0]);
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_lane    = mem_rdata >> {r_off, 3'b000};

  load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_word   (w_lane),
    .o_word   (w_ext)
  );

  // Grant / read-valid take priority over a timeout expiring in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_rdata_next = r_resp_rdata;
    w_err_next   = r_resp_err;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_legal) begin
            w_state_next = ST_REQ;
          end else begin
            w_state_next = ST_RESP;
            w_rdata_next = '0;
            w_err_next   = ERR_ALIGN;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (r_store) begin
            w_state_next = ST_RESP;
            w_rdata_next = '0;
            w_err_next   = ERR_OK;
          end else begin
            w_state_next = ST_WAIT;
          end
        end else if (w_timeout) begin
          w_state_next = ST_RESP;
          w_rdata_next = '0;
          w_err_next   = ERR_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_state_next = ST_RESP;
          w_rdata_next = w_ext;
          w_err_next   = ERR_OK;
        end else if (w_timeout) begin
          w_state_next = ST_RESP;
          w_rdata_next = '0;
          w_err_next   = ERR_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (resp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_store      <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= (w_state_next == ST_RESP);
      r_resp_rdata <= w_rdata_next;
      r_resp_err   <= w_err_next;
      r_mem_req    <= (w_state_next == ST_REQ);

      unique case (r_state)
        ST_IDLE:          r_cnt <= '0;
        ST_REQ, ST_WAIT:  r_cnt <= r_cnt + CW'(1);
        default:          r_cnt <= r_cnt;
      endcase

      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_off    <= req_addr[1:0];
        if (w_legal) begin
          r_mem_addr  <= {req_addr[31:2], 2'b00};
          r_mem_we    <= req_store;
          r_mem_wstrb <= req_store ? lsu_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
          r_mem_wdata <= req_store ? (req_wdata << {req_addr[1:0], 3'b000}) : '0;
        end
      end

      if ((r_state == ST_REQ) && (w_state_next != ST_REQ)) begin
        r_mem_we    <= 1'b0;
        r_mem_wstrb <= '0;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, illegal accesses, timeout,
// response back-pressure and mid-transaction reset.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    chk("req_ready_at_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_idle_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load_zw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [31:0] rd,
                         input logic [31:0] exp_rd);
    accept(1'b0, f3, a, 32'h0);
    chk({tag, "_c1_mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_c1_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_c1_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_c1_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    chk({tag, "_c1_resp_valid"}, 32'(resp_valid), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_c2_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_c2_resp_valid"}, 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_c3_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_c3_resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_c3_resp_err"}, 32'(resp_err), 32'd0);
    finish_resp(tag);
  endtask

  task automatic store_zw(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    accept(1'b1, f3, a, wd);
    chk({tag, "_c1_mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_c1_mem_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_c1_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_c1_mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
    chk({tag, "_c1_mem_wdata"}, mem_wdata, exp_wd);
    chk({tag, "_c1_resp_valid"}, 32'(resp_valid), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_c2_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_c2_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_c2_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_c2_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_c2_mem_we"}, 32'(mem_we), 32'd0);
    finish_resp(tag);
  endtask

  task automatic illegal(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a);
    accept(st, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd1);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    finish_resp(tag);
    chk({tag, "_mem_req_after"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    load_zw("lb", 3'b000, 32'h0000_1003, 32'h0000_1000, 32'h80FF_0000, 32'hFFFF_FF80);
    load_zw("lhu", 3'b101, 32'h0000_2002, 32'h0000_2000, 32'hBEEF_1234, 32'h0000_BEEF);
    load_zw("lh", 3'b001, 32'h0000_2002, 32'h0000_2000, 32'hBEEF_1234, 32'hFFFF_BEEF);
    load_zw("lbu", 3'b100, 32'h0000_2001, 32'h0000_2000, 32'h0000_9A00, 32'h0000_009A);

    illegal("lw_mis", 1'b0, 3'b010, 32'h0000_2001);
    illegal("lh_mis", 1'b0, 3'b001, 32'h0000_2003);
    illegal("ld_f3", 1'b0, 3'b011, 32'h0000_2000);
    illegal("st_f3", 1'b1, 3'b100, 32'h0000_2000);

    store_zw("sb", 3'b000, 32'h0000_3002, 32'h0000_00AB, 32'h0000_3000, 4'b0100, 32'h00AB_0000);
    store_zw("sh", 3'b001, 32'h0000_3002, 32'h0000_1234, 32'h0000_3000, 4'b1100, 32'h1234_0000);

    // Timeout: grant never comes, 8 cycles in REQ
    accept(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("to_req_c%0d_mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("to_req_c%0d_resp_valid", i), 32'(resp_valid), 32'd0);
      tick();
    end
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_err", 32'(resp_err), 32'd2);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_resp_rdata", resp_rdata, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk("to_late_rvalid_rdata", resp_rdata, 32'h0);
    chk("to_late_rvalid_err", 32'(resp_err), 32'd2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    chk("to_idle_resp_valid", 32'(resp_valid), 32'd0);
    chk("to_idle_req_ready", 32'(req_ready), 32'd1);

    // Grant arrives on the very cycle the timeout would fire
    accept(1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D);
    chk("sw_wstrb", 32'(mem_wstrb), 32'h0000_000F);
    chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    for (int i = 1; i <= 7; i++) tick();
    chk("sw_c8_mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sw_gnt_wins_valid", 32'(resp_valid), 32'd1);
    chk("sw_gnt_wins_err", 32'(resp_err), 32'd0);
    chk("sw_resp_wstrb", 32'(mem_wstrb), 32'd0);
    finish_resp("sw");

    // Back-pressure on the response
    accept(1'b0, 3'b010, 32'h0000_5000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1122_3344;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_c%0d_resp_valid", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_c%0d_resp_rdata", i), resp_rdata, 32'h1122_3344);
      chk($sformatf("bp_c%0d_req_ready", i), 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    chk("bp_hs_req_ready", 32'(req_ready), 32'd0);
    tick();
    resp_ready = 1'b0;
    chk("bp_after_req_ready", 32'(req_ready), 32'd1);
    chk("bp_after_resp_valid", 32'(resp_valid), 32'd0);

    // Reset while waiting for read data
    accept(1'b0, 3'b010, 32'h0000_7000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rw_resp_err", 32'(resp_err), 32'd0);
    tick();
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    load_zw("lw0", 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h5A5A_A5A5, 32'h5A5A_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
